// File: rtl/ltsm_rdi_cmd_responder_if.sv
// ltsm_rdi_cmd_responder_if
//   Bundles the RDI request levels and the LTSM command handshake.
//   slave  : responder side (consumes requests, drives the command handshake)
//   master : LTSM core / stimulus side
// Signals:
//   i_req_vec     [7:0] synchronized request levels (bit index = command code)
//   i_cmd_ready         core accepts the offered command
//   i_cmd_done          single-cycle pulse, accepted command finished
//   o_cmd_valid         command offered
//   o_cmd         [2:0] command code
//   o_abort             pulse, running command preempted by linkerror
//   o_timeout           pulse, done not seen in time
//   o_train_error       sticky error level toward RDI
//   o_busy              responder not idle
interface ltsm_rdi_cmd_responder_if;
  logic [7:0] i_req_vec;
  logic       i_cmd_ready;
  logic       i_cmd_done;
  logic       o_cmd_valid;
  logic [2:0] o_cmd;
  logic       o_abort;
  logic       o_timeout;
  logic       o_train_error;
  logic       o_busy;

  modport slave (
    input  i_req_vec, i_cmd_ready, i_cmd_done,
    output o_cmd_valid, o_cmd, o_abort, o_timeout, o_train_error, o_busy
  );

  modport master (
    output i_req_vec, i_cmd_ready, i_cmd_done,
    input  o_cmd_valid, o_cmd, o_abort, o_timeout, o_train_error, o_busy
  );
endinterface

// File: rtl/ltsm_rdi_cmd_responder.sv
// ltsm_rdi_cmd_responder
//   LTSM-side responder for RDI request levels (clk_ltsm domain). Qualifies the
//   bit-synchronized request vector against inter-bit skew, priority-encodes
//   pending requests into single commands, runs a valid/ready + done handshake
//   with the LTSM core, and keeps a sticky training-error status.
// Ports:
//   clk_ltsm    LTSM clock
//   i_rst_n_mb  asynchronous active-low reset
//   rdi         request/handshake bundle (slave modport)
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | nothing in flight; picks highest-priority pending bit
// ISSUE     | o_cmd_valid high, o_cmd held until i_cmd_ready
// WAIT_DONE | command accepted; waiting for done, preemption or timeout
module ltsm_rdi_cmd_responder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_ltsm,
  input  logic                       i_rst_n_mb,
  ltsm_rdi_cmd_responder_if.slave    rdi
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  vec_q;
  logic [7:0]  qvec_q, qvec_d;
  logic [3:0]  stable_cnt_q, stable_cnt_d;
  logic [7:0]  pending_q, pending_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        abort_q, abort_d;
  logic        timeout_q, timeout_d;
  logic        train_err_q, train_err_d;
  logic        busy_q, busy_d;

  logic        qualify;
  logic [7:0]  pend_base;
  logic [7:0]  clr_mask;
  logic [2:0]  win_idx;

  // Skew qualifier: the vector must sit unchanged for STABLE_CYCLES edges.
  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (rdi.i_req_vec != vec_q)
      stable_cnt_d = '0;
    else if (stable_cnt_q != STABLE_MAX)
      stable_cnt_d = stable_cnt_q + 4'd1;
  end

  assign qualify = (stable_cnt_q == STABLE_MAX);

  // Lowest set bit wins; scanning downward leaves the lowest index last.
  always_comb begin
    win_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pending_q[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    tmo_cnt_d   = tmo_cnt_q;
    abort_d     = 1'b0;
    timeout_d   = 1'b0;
    train_err_d = train_err_q;
    clr_mask    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          state_d = ST_ISSUE;
          cmd_d   = win_idx;
        end
      end
      ST_ISSUE: begin
        if (rdi.i_cmd_ready) begin
          clr_mask  = 8'd1 << cmd_q;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (rdi.i_cmd_done) begin
          state_d = ST_IDLE;
          if (cmd_q == 3'd1) train_err_d = 1'b0;
        end else if (pending_q[0] && (cmd_q != 3'd0)) begin
          // linkerror preempts whatever is running
          abort_d = 1'b1;
          cmd_d   = 3'd0;
          state_d = ST_ISSUE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d   = 1'b1;
          train_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // New qualified rising bits pend; withdrawn levels drop; accepted bit clears.
  always_comb begin
    pend_base = qualify ? ((pending_q | (vec_q & ~qvec_q)) & vec_q) : pending_q;
    pending_d = pend_base & ~clr_mask;
    qvec_d    = qualify ? vec_q : qvec_q;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_ltsm or negedge i_rst_n_mb) begin
    if (!i_rst_n_mb) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      qvec_q       <= '0;
      stable_cnt_q <= '0;
      pending_q    <= '0;
      cmd_q        <= '0;
      tmo_cnt_q    <= '0;
      abort_q      <= 1'b0;
      timeout_q    <= 1'b0;
      train_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= rdi.i_req_vec;
      qvec_q       <= qvec_d;
      stable_cnt_q <= stable_cnt_d;
      pending_q    <= pending_d;
      cmd_q        <= cmd_d;
      tmo_cnt_q    <= tmo_cnt_d;
      abort_q      <= abort_d;
      timeout_q    <= timeout_d;
      train_err_q  <= train_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rdi.o_cmd_valid   = (state_q == ST_ISSUE);
  assign rdi.o_cmd         = cmd_q;
  assign rdi.o_abort       = abort_q;
  assign rdi.o_timeout     = timeout_q;
  assign rdi.o_train_error = train_err_q;
  assign rdi.o_busy        = busy_q;

endmodule

// File: tb/tb_ltsm_rdi_cmd_responder.sv
// tb_ltsm_rdi_cmd_responder
//   Self-checking bench: expected command codes are queued when requests are
//   driven and compared against each handshake transfer; scenario tasks check
//   latency, pulses and status levels inline.
module tb_ltsm_rdi_cmd_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ltsm_rdi_cmd_responder_if bus();

  ltsm_rdi_cmd_responder #(
    .STABLE_CYCLES (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_ltsm  (clk),
    .i_rst_n_mb(rst_n),
    .rdi       (bus)
  );

  int errors   = 0;
  int checks   = 0;
  int xfer_cnt = 0;
  int unsigned exp_q[$];
  logic [2:0] exp_cmd;

  always #5 clk = ~clk;

  // Scoreboard: every transfer (valid & ready ahead of a posedge) pops one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_cmd_valid && bus.i_cmd_ready) begin
        checks++;
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: issued cmd=%0d, required no command", bus.o_cmd);
        end else begin
          exp_cmd = 3'(exp_q.pop_front());
          if (bus.o_cmd !== exp_cmd) begin
            errors++;
            $display("FAIL sb_cmd: issued cmd=%0d, required %0d", bus.o_cmd, exp_cmd);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int target, input string name);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (xfer_cnt >= target) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: transfers=%0d, required %0d within 20 edges", name, xfer_cnt, target);
    end
  endtask

  task automatic pulse_done();
    bus.i_cmd_done = 1'b1;
    tick(1);
    bus.i_cmd_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_req_vec   = 8'h00;
    bus.i_cmd_ready = 1'b0;
    bus.i_cmd_done  = 1'b0;
    rst_n = 1'b0;
    #23;
    checks++;
    if ({bus.o_cmd_valid, bus.o_cmd, bus.o_abort, bus.o_timeout, bus.o_train_error, bus.o_busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b cmd=%0d abort=%b timeout=%b err=%b busy=%b, required all 0",
               bus.o_cmd_valid, bus.o_cmd, bus.o_abort, bus.o_timeout, bus.o_train_error, bus.o_busy);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(5);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b, required 0 0", bus.o_busy, bus.o_cmd_valid);
    end
  endtask

  task automatic test_single();
    int base;
    base = xfer_cnt;
    bus.i_cmd_ready = 1'b1;
    bus.i_req_vec = 8'h20;
    exp_q.push_back(5);
    tick(4);
    checks++;
    if (bus.o_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: valid=%b after E3, required 0", bus.o_cmd_valid);
    end
    tick(1);
    checks++;
    if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd !== 3'd5 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: valid=%b cmd=%0d busy=%b after E4, required 1 5 1",
               bus.o_cmd_valid, bus.o_cmd, bus.o_busy);
    end
    tick(1);
    checks++;
    if (bus.o_cmd_valid !== 1'b0 || bus.o_busy !== 1'b1 || xfer_cnt != base + 1) begin
      errors++;
      $display("FAIL single_xfer: valid=%b busy=%b transfers=%0d, required 0 1 %0d",
               bus.o_cmd_valid, bus.o_busy, xfer_cnt - base, 1);
    end
    pulse_done();
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done_busy: busy=%b after done edge, required 0", bus.o_busy);
    end
    bus.i_req_vec = 8'h00;
    tick(6);
  endtask

  task automatic test_skew();
    int base;
    base = xfer_cnt;
    bus.i_cmd_ready = 1'b1;
    bus.i_req_vec = 8'h40;
    exp_q.push_back(6);
    exp_q.push_back(7);
    tick(1);
    bus.i_req_vec = 8'hC0;
    wait_xfer(base + 1, "skew_first");
    pulse_done();
    wait_xfer(base + 2, "skew_second");
    pulse_done();
    tick(10);
    checks++;
    if (xfer_cnt != base + 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL skew_count: transfers=%0d left=%0d, required 2 0", xfer_cnt - base, exp_q.size());
    end
    bus.i_req_vec = 8'h00;
    tick(6);
  endtask

  task automatic test_glitch();
    int base;
    bit seen;
    base = xfer_cnt;
    seen = 1'b0;
    bus.i_cmd_ready = 1'b1;
    bus.i_req_vec = 8'h08;
    tick(1);
    bus.i_req_vec = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bus.o_cmd_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || xfer_cnt != base) begin
      errors++;
      $display("FAIL glitch: valid_seen=%b transfers=%0d, required 0 0", seen, xfer_cnt - base);
    end
  endtask

  task automatic test_preempt();
    int base;
    int aborts;
    logic [2:0] ab_cmd;
    logic ab_valid;
    base = xfer_cnt;
    aborts = 0;
    ab_cmd = 3'd7;
    ab_valid = 1'b0;
    bus.i_cmd_ready = 1'b1;
    bus.i_req_vec = 8'h08;
    exp_q.push_back(3);
    wait_xfer(base + 1, "preempt_first");
    bus.i_req_vec = 8'h09;
    exp_q.push_back(0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (bus.o_abort === 1'b1) begin
        aborts++;
        ab_cmd = bus.o_cmd;
        ab_valid = bus.o_cmd_valid;
      end
    end
    checks++;
    if (aborts != 1) begin
      errors++;
      $display("FAIL preempt_abort_count: aborts=%0d, required 1", aborts);
    end
    checks++;
    if (ab_cmd !== 3'd0 || ab_valid !== 1'b1) begin
      errors++;
      $display("FAIL preempt_offer: cmd=%0d valid=%b at abort, required 0 1", ab_cmd, ab_valid);
    end
    checks++;
    if (xfer_cnt != base + 2) begin
      errors++;
      $display("FAIL preempt_xfer: transfers=%0d, required 2", xfer_cnt - base);
    end
    pulse_done();
    bus.i_req_vec = 8'h00;
    tick(8);
    checks++;
    if (xfer_cnt != base + 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL preempt_no_reissue: transfers=%0d left=%0d, required 2 0", xfer_cnt - base, exp_q.size());
    end

    // done coincides with a pending linkerror: done wins, no abort
    base = xfer_cnt;
    aborts = 0;
    bus.i_req_vec = 8'h08;
    exp_q.push_back(3);
    wait_xfer(base + 1, "race_first");
    bus.i_req_vec = 8'h09;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (bus.o_abort === 1'b1) aborts++;
    end
    exp_q.push_back(0);
    bus.i_cmd_done = 1'b1;
    tick(1);
    bus.i_cmd_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus.o_abort === 1'b1) aborts++;
      tick(1);
    end
    checks++;
    if (aborts != 0 || xfer_cnt != base + 2) begin
      errors++;
      $display("FAIL race_done_wins: aborts=%0d transfers=%0d, required 0 2", aborts, xfer_cnt - base);
    end
    pulse_done();
    bus.i_req_vec = 8'h00;
    tick(8);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL race_left: left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int base;
    int first;
    int n;
    base = xfer_cnt;
    first = 0;
    n = 0;
    bus.i_cmd_ready = 1'b1;
    bus.i_req_vec = 8'h10;
    exp_q.push_back(4);
    wait_xfer(base + 1, "timeout_xfer");
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (bus.o_timeout === 1'b1) begin
        n++;
        if (first == 0) first = k;
      end
    end
    checks++;
    if (first != 8 || n != 1) begin
      errors++;
      $display("FAIL timeout_pulse: first_edge=%0d width=%0d, required 8 1", first, n);
    end
    checks++;
    if (bus.o_train_error !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status: err=%b busy=%b, required 1 0", bus.o_train_error, bus.o_busy);
    end
    bus.i_req_vec = 8'h12;
    exp_q.push_back(1);
    wait_xfer(base + 2, "timeout_reset_xfer");
    checks++;
    if (bus.o_train_error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err_hold: err=%b before done, required 1", bus.o_train_error);
    end
    pulse_done();
    checks++;
    if (bus.o_train_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_clear: err=%b after reset done, required 0", bus.o_train_error);
    end
    bus.i_req_vec = 8'h00;
    tick(8);
  endtask

  task automatic test_rst_issue();
    int base;
    bit got;
    base = xfer_cnt;
    got = 1'b0;
    bus.i_cmd_ready = 1'b0;
    bus.i_req_vec = 8'h04;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bus.o_cmd_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_reach_issue: valid=%b, required 1 within 10 edges", bus.o_cmd_valid);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_cmd_valid, bus.o_cmd, bus.o_abort, bus.o_timeout, bus.o_train_error, bus.o_busy} !== 8'h00) begin
      errors++;
      $display("FAIL rst_async: valid=%b cmd=%0d abort=%b timeout=%b err=%b busy=%b, required all 0",
               bus.o_cmd_valid, bus.o_cmd, bus.o_abort, bus.o_timeout, bus.o_train_error, bus.o_busy);
    end
    tick(2);
    rst_n = 1'b1;
    tick(4);
    checks++;
    if (bus.o_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_requal_early: valid=%b after E3, required 0", bus.o_cmd_valid);
    end
    tick(1);
    checks++;
    if (bus.o_cmd_valid !== 1'b1 || bus.o_cmd !== 3'd2) begin
      errors++;
      $display("FAIL rst_requal_issue: valid=%b cmd=%0d after E4, required 1 2", bus.o_cmd_valid, bus.o_cmd);
    end
    exp_q.push_back(2);
    bus.i_cmd_ready = 1'b1;
    wait_xfer(base + 1, "rst_xfer");
    pulse_done();
    bus.i_req_vec = 8'h00;
    tick(8);
    checks++;
    if (xfer_cnt != base + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_count: transfers=%0d left=%0d, required 1 0", xfer_cnt - base, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_skew();
    test_glitch();
    test_preempt();
    test_timeout();
    test_rst_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ltsm_rdi_cmd_responder.md
# ltsm_rdi_cmd_responder

LTSM-side responder for the RDI-to-LTSM request levels, in the `clk_ltsm` domain. It consumes the already bit-synchronized `go_to_*` and `exit_from_l1` levels and qualifies them against inter-bit synchronizer skew. It priority-encodes them into single commands and issues each one to the LTSM core over a valid/ready plus done handshake. It also returns a sticky training-error status toward RDI.

## Interface
- `STABLE_CYCLES`, default 2: edges a request vector must hold unchanged before it is qualified (1..15).
- `TIMEOUT_CYCLES`, default 1024: maximum `clk_ltsm` edges spent in WAIT_DONE (2..65535).
- `clk_ltsm`  in  1  LTSM clock.
- `i_rst_n_mb`  in  1  asynchronous active-low reset.
- `i_req_vec`  in  8  synchronized request levels; bit0 linkerror, 1 reset, 2 retrain, 3 training, 4 exit_from_l1, 5 active, 6 l2, 7 l1.
- `i_cmd_ready`  in  1  LTSM core accepts the command.
- `i_cmd_done`  in  1  single-cycle pulse: accepted command finished.
- `o_cmd_valid`  out  1  command offered.
- `o_cmd`  out  3  command code = bit index of `i_req_vec`.
- `o_abort`  out  1  single-cycle pulse: running command preempted.
- `o_timeout`  out  1  single-cycle pulse: done not received in time.
- `o_train_error`  out  1  sticky error level toward RDI.
- `o_busy`  out  1  state is not IDLE.

## Operation
- Qualifier:
  - `vec_q` samples `i_req_vec` every edge.
  - `stable_cnt` is 4 bits. It clears to 0 on an edge where `i_req_vec != vec_q`; otherwise it increments, saturating at STABLE_CYCLES.
  - On any edge with `stable_cnt == STABLE_CYCLES`:
    - `q_vec <= vec_q`;
    - `pending <= (pending | (vec_q & ~q_vec)) & vec_q`. Rising qualified bits set `pending`; bits whose level has been withdrawn clear `pending`.
- Priority: lowest set bit of `pending` wins, so linkerror > reset > retrain > training > exit_l1 > active > l2 > l1.
- FSM has three states: IDLE, ISSUE, WAIT_DONE.
  - IDLE → ISSUE when `pending != 0`. At that transition `o_cmd` latches the winning index.
  - ISSUE:
    - `o_cmd_valid = 1`.
    - `o_cmd` is held stable until an edge with `i_cmd_ready = 1`.
    - On that edge the matching `pending` bit clears, the timeout counter clears, and the state goes to WAIT_DONE.
    - The offer is never withdrawn, even if its level falls.
  - WAIT_DONE, evaluated in priority order:
    - `i_cmd_done` → IDLE. If `o_cmd == 1` (reset), also clear `o_train_error`.
    - Else if `pending[0]` and `o_cmd != 0` → pulse `o_abort`, latch `o_cmd = 0`, go to ISSUE.
    - Else if the counter reaches TIMEOUT_CYCLES-1 → pulse `o_timeout`, set `o_train_error`, go to IDLE.
    - Else the counter increments.
- `i_cmd_done` outside WAIT_DONE is ignored. `i_cmd_ready` outside ISSUE is ignored.
- A rising edge of a bit that is already pending is a no-op. A rising edge of the running command's bit re-pends it, and it is reissued after done.

## Timing
- Reset values: all outputs 0; state IDLE; `vec_q`, `q_vec`, `pending` and all counters 0.
- The asynchronous reset takes effect mid-handshake with no completion pulse.
- Latency: `i_req_vec` changes before edge E0.
  - E0: `vec_q` updated, `stable_cnt = 0`.
  - E(STABLE_CYCLES+1): `pending` set.
  - E(STABLE_CYCLES+2): `o_cmd_valid` high. With the default, that is after the 4th edge.
- A change in the vector during qualification restarts the count at 0.
- Handshake: transfer occurs on the edge where `o_cmd_valid & i_cmd_ready`. `o_cmd_valid` is low the following cycle.
- Done-to-next-issue: the done edge returns to IDLE. A remaining pending bit raises `o_cmd_valid` one edge later.
- Timeout: with ready at edge A and no done, `o_timeout` pulses after edge A+TIMEOUT_CYCLES.
- `o_abort` and `o_timeout` are registered pulses exactly one cycle wide.
- `o_busy` is registered: it goes high the same edge the state leaves IDLE.

## Test plan
- Single request: `i_req_vec = 8'h20` at E0, `i_cmd_ready = 1` → `o_cmd_valid` after E4 with `o_cmd = 5`. Transfer at E5, then `o_cmd_valid = 0`. Done pulse → `o_busy = 0` next edge.
- Skew: `8'h40` then `8'hC0` one edge later → only one qualification. `o_cmd = 6` issued first, then `o_cmd = 7` after done. Neither is issued twice.
- Glitch: `8'h08` held for 1 edge then `8'h00` → `pending` never set, `o_cmd_valid` stays 0.
- Preemption: `o_cmd = 3` in WAIT_DONE, `i_req_vec` bit0 rises → `o_abort` pulses once, `o_cmd = 0` offered. A done arriving on the same edge as pending linkerror → no abort, linkerror is issued from IDLE.
- Timeout: `TIMEOUT_CYCLES = 8`, command accepted, no done → `o_timeout` pulse 8 edges after acceptance and `o_train_error = 1`. A subsequent reset request (`o_cmd = 1`) plus done → `o_train_error = 0`.
- Reset: assert `i_rst_n_mb` low while in ISSUE → all outputs 0 asynchronously. After release, a still-high request is requalified and reissued at E(STABLE_CYCLES+2).
